// File: rtl/btb_update_ctrl.sv
// ============================================================================
//  Module      : btb_update_ctrl
//  Description : Tracks BTB predictions from fetch in an in-order FIFO and
//                resolves them against EX outcomes. Produces registered BTB
//                update controls, pipeline flush and redirect PC.
//                Optional macro BTB_PERF_CNT_EN adds saturating perf counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btb_update_ctrl #(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    input  logic        btb_valid,
    input  logic        btb_taken,
    input  logic [31:0] btb_target,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_is_branch,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    output logic        fetch_stall,
    output logic        update,
    output logic [31:0] update_pc,
    output logic [31:0] update_target,
    output logic        mispredicted,
    output logic        flush,
    output logic [31:0] redirect_pc,
`ifdef BTB_PERF_CNT_EN
    output logic [31:0] perf_branches,
    output logic [31:0] perf_mispredicts,
`endif
    output logic        pc_mismatch
);

    localparam logic [PTR_W:0] c_full_cnt = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] c_one_cnt  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] c_one_ptr = PTR_W'(1);

    // Tracking storage (data only, no reset needed)
    logic [31:0]      r_pc_mem  [DEPTH];
    logic             r_tk_mem  [DEPTH];
    logic [31:0]      r_tgt_mem [DEPTH];

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic             r_update;
    logic [31:0]      r_update_pc;
    logic [31:0]      r_update_target;
    logic             r_mispredicted;
    logic             r_flush;
    logic [31:0]      r_redirect_pc;
    logic             r_pc_mismatch;

    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_kill;
    logic [31:0]      w_head_pc;
    logic             w_head_tk;
    logic [31:0]      w_head_tgt;
    logic [31:0]      w_pred_next;
    logic [31:0]      w_act_next;
    logic             w_miss;

    assign w_full     = (r_count == c_full_cnt);
    assign w_head_pc  = r_pc_mem[r_rd_ptr];
    assign w_head_tk  = r_tk_mem[r_rd_ptr];
    assign w_head_tgt = r_tgt_mem[r_rd_ptr];

    assign w_pop       = ex_valid & (r_count != '0);
    assign w_pred_next = w_head_tk ? w_head_tgt : (w_head_pc + 32'd4);
    assign w_act_next  = (ex_is_branch & ex_taken) ? ex_target : (ex_pc + 32'd4);
    assign w_miss      = (w_pred_next != w_act_next);
    assign w_kill      = w_pop & w_miss;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a
    // push alongside a pop. The registered flush acts as flush_pending.
    assign w_push = if_valid & (~w_full | w_pop) & ~r_flush & ~w_kill;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]  <= if_pc;
            r_tk_mem[r_wr_ptr]  <= btb_valid & btb_taken;
            r_tgt_mem[r_wr_ptr] <= btb_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_kill) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_one_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_one_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_one_cnt;
                2'b01:   r_count <= r_count - c_one_cnt;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_update        <= 1'b0;
            r_update_pc     <= '0;
            r_update_target <= '0;
            r_mispredicted  <= 1'b0;
            r_flush         <= 1'b0;
            r_redirect_pc   <= '0;
            r_pc_mismatch   <= 1'b0;
        end else begin
            r_update       <= w_pop & ex_is_branch;
            r_mispredicted <= w_kill;
            r_flush        <= w_kill;
            if (w_pop & ex_is_branch) begin
                r_update_pc     <= ex_pc;
                r_update_target <= ex_target;
            end
            if (w_kill) begin
                r_redirect_pc <= w_act_next;
            end
            if (w_pop && (ex_pc != w_head_pc)) begin
                r_pc_mismatch <= 1'b1;
            end
        end
    end

`ifdef BTB_PERF_CNT_EN
    logic [31:0] r_perf_branches;
    logic [31:0] r_perf_mispredicts;

    // Non-branch flushes never raise update, so they count in neither.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_branches    <= '0;
            r_perf_mispredicts <= '0;
        end else begin
            if (r_update && (r_perf_branches != '1)) begin
                r_perf_branches <= r_perf_branches + 32'd1;
            end
            if (r_update && r_mispredicted && (r_perf_mispredicts != '1)) begin
                r_perf_mispredicts <= r_perf_mispredicts + 32'd1;
            end
        end
    end

    assign perf_branches    = r_perf_branches;
    assign perf_mispredicts = r_perf_mispredicts;
`endif

    assign fetch_stall   = w_full;
    assign update        = r_update;
    assign update_pc     = r_update_pc;
    assign update_target = r_update_target;
    assign mispredicted  = r_mispredicted;
    assign flush         = r_flush;
    assign redirect_pc   = r_redirect_pc;
    assign pc_mismatch   = r_pc_mismatch;

endmodule

`default_nettype wire

// File: tb/tb_btb_update_ctrl.sv
// ============================================================================
//  Module      : tb_btb_update_ctrl
//  Description : Self-checking bench for btb_update_ctrl (DEPTH = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_btb_update_ctrl;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        btb_valid;
    logic        btb_taken;
    logic [31:0] btb_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_is_branch;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        fetch_stall;
    logic        update;
    logic [31:0] update_pc;
    logic [31:0] update_target;
    logic        mispredicted;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        pc_mismatch;
`ifdef BTB_PERF_CNT_EN
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    btb_update_ctrl #(.DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .btb_valid     (btb_valid),
        .btb_taken     (btb_taken),
        .btb_target    (btb_target),
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .ex_is_branch  (ex_is_branch),
        .ex_taken      (ex_taken),
        .ex_target     (ex_target),
        .fetch_stall   (fetch_stall),
        .update        (update),
        .update_pc     (update_pc),
        .update_target (update_target),
        .mispredicted  (mispredicted),
        .flush         (flush),
        .redirect_pc   (redirect_pc),
`ifdef BTB_PERF_CNT_EN
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts),
`endif
        .pc_mismatch   (pc_mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        iv;
        logic [31:0] ipc;
        logic        bv;
        logic        bt;
        logic [31:0] btgt;
        logic        ev;
        logic [31:0] epc;
        logic        br;
        logic        tk;
        logic [31:0] etgt;
        logic        e_upd;
        logic [31:0] e_upc;
        logic [31:0] e_utgt;
        logic        e_mis;
        logic        e_flush;
        logic [31:0] e_redir;
        logic        e_stall;
        logic        e_mism;
    } vec_t;

    vec_t vecs [10];

    function automatic vec_t mk(
        input logic iv, input logic [31:0] ipc, input logic bv, input logic bt,
        input logic [31:0] btgt, input logic ev, input logic [31:0] epc,
        input logic br, input logic tk, input logic [31:0] etgt,
        input logic e_upd, input logic [31:0] e_upc, input logic [31:0] e_utgt,
        input logic e_mis, input logic e_flush, input logic [31:0] e_redir,
        input logic e_stall, input logic e_mism);
        vec_t v;
        v.iv = iv; v.ipc = ipc; v.bv = bv; v.bt = bt; v.btgt = btgt;
        v.ev = ev; v.epc = epc; v.br = br; v.tk = tk; v.etgt = etgt;
        v.e_upd = e_upd; v.e_upc = e_upc; v.e_utgt = e_utgt; v.e_mis = e_mis;
        v.e_flush = e_flush; v.e_redir = e_redir; v.e_stall = e_stall;
        v.e_mism = e_mism;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs, then settle just after the active edge.
    task automatic drive(
        input logic iv, input logic [31:0] ipc, input logic bv, input logic bt,
        input logic [31:0] btgt, input logic ev, input logic [31:0] epc,
        input logic br, input logic tk, input logic [31:0] etgt);
        if_valid = iv; if_pc = ipc; btb_valid = bv; btb_taken = bt; btb_target = btgt;
        ex_valid = ev; ex_pc = epc; ex_is_branch = br; ex_taken = tk; ex_target = etgt;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    logic [31:0] q[$];
    logic [31:0] h;
    logic [31:0] pc_next;

    initial begin
        //                iv  ipc           bv bt btgt      ev epc           br tk etgt       upd upc           utgt        mis fl redir       st mm
        vecs[0] = mk(1, 32'h100,      1, 1, 32'h200, 0, 32'h0,       0, 0, 32'h0,    0, 32'h0,       32'h0,    0, 0, 32'h0,  0, 0);
        vecs[1] = mk(0, 32'h0,        0, 0, 32'h0,   1, 32'h100,     1, 1, 32'h200,  1, 32'h100,     32'h200,  0, 0, 32'h0,  0, 0);
        vecs[2] = mk(1, 32'h40,       0, 0, 32'h0,   0, 32'h0,       0, 0, 32'h0,    0, 32'h100,     32'h200,  0, 0, 32'h0,  0, 0);
        vecs[3] = mk(1, 32'h44,       0, 0, 32'h0,   1, 32'h40,      1, 1, 32'h80,   1, 32'h40,      32'h80,   1, 1, 32'h80, 0, 0);
        vecs[4] = mk(1, 32'h48,       0, 0, 32'h0,   1, 32'h48,      1, 0, 32'h0,    0, 32'h40,      32'h80,   0, 0, 32'h80, 0, 0);
        vecs[5] = mk(1, 32'h10,       1, 1, 32'h300, 0, 32'h0,       0, 0, 32'h0,    0, 32'h40,      32'h80,   0, 0, 32'h80, 0, 0);
        vecs[6] = mk(0, 32'h0,        0, 0, 32'h0,   1, 32'h10,      0, 0, 32'h0,    0, 32'h40,      32'h80,   1, 1, 32'h14, 0, 0);
        vecs[7] = mk(0, 32'h0,        0, 0, 32'h0,   0, 32'h0,       0, 0, 32'h0,    0, 32'h40,      32'h80,   0, 0, 32'h14, 0, 0);
        vecs[8] = mk(1, 32'hFFFFFFFC, 0, 0, 32'h0,   0, 32'h0,       0, 0, 32'h0,    0, 32'h40,      32'h80,   0, 0, 32'h14, 0, 0);
        vecs[9] = mk(0, 32'h0,        0, 0, 32'h0,   1, 32'hFFFFFFFC,1, 0, 32'h1234, 1, 32'hFFFFFFFC,32'h1234, 0, 0, 32'h14, 0, 0);

        if_valid = 0; if_pc = 0; btb_valid = 0; btb_taken = 0; btb_target = 0;
        ex_valid = 0; ex_pc = 0; ex_is_branch = 0; ex_taken = 0; ex_target = 0;
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("reset_update",      {31'b0, update},      32'h0);
        chk("reset_flush",       {31'b0, flush},       32'h0);
        chk("reset_stall",       {31'b0, fetch_stall}, 32'h0);
        chk("reset_update_pc",   update_pc,            32'h0);
        chk("reset_redirect",    redirect_pc,          32'h0);
        chk("reset_mismatch",    {31'b0, pc_mismatch}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].iv, vecs[i].ipc, vecs[i].bv, vecs[i].bt, vecs[i].btgt,
                  vecs[i].ev, vecs[i].epc, vecs[i].br, vecs[i].tk, vecs[i].etgt);
            chk($sformatf("v%0d_update", i),   {31'b0, update},      {31'b0, vecs[i].e_upd});
            chk($sformatf("v%0d_update_pc", i), update_pc,           vecs[i].e_upc);
            chk($sformatf("v%0d_update_tgt", i), update_target,      vecs[i].e_utgt);
            if (vecs[i].e_upd || vecs[i].e_flush)
                chk($sformatf("v%0d_mispred", i), {31'b0, mispredicted}, {31'b0, vecs[i].e_mis});
            chk($sformatf("v%0d_flush", i),    {31'b0, flush},       {31'b0, vecs[i].e_flush});
            chk($sformatf("v%0d_redirect", i), redirect_pc,          vecs[i].e_redir);
            chk($sformatf("v%0d_stall", i),    {31'b0, fetch_stall}, {31'b0, vecs[i].e_stall});
            chk($sformatf("v%0d_pc_mism", i),  {31'b0, pc_mismatch}, {31'b0, vecs[i].e_mism});
        end

        // Fill to full, then pop+push while full, then drain across the wrap.
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'(4 * i), 1, 1, 32'(4 * i) + 32'h1000, 0, 0, 0, 0, 0);
            q.push_back(32'(4 * i));
        end
        chk("full_stall", {31'b0, fetch_stall}, 32'h1);
        pc_next = 32'h10;
        for (int i = 0; i < 9; i++) begin
            h = q.pop_front();
            drive(1, pc_next, 1, 1, pc_next + 32'h1000, 1, h, 1, 1, h + 32'h1000);
            q.push_back(pc_next);
            pc_next = pc_next + 32'd4;
            chk($sformatf("wrap%0d_stall", i),  {31'b0, fetch_stall}, 32'h1);
            chk($sformatf("wrap%0d_update", i), {31'b0, update},      32'h1);
            chk($sformatf("wrap%0d_flush", i),  {31'b0, flush},       32'h0);
            chk($sformatf("wrap%0d_mism", i),   {31'b0, pc_mismatch}, 32'h0);
        end
        for (int i = 0; i < 4; i++) begin
            h = q.pop_front();
            drive(0, 0, 0, 0, 0, 1, h, 1, 1, h + 32'h1000);
            chk($sformatf("drain%0d_flush", i), {31'b0, flush},       32'h0);
            chk($sformatf("drain%0d_mism", i),  {31'b0, pc_mismatch}, 32'h0);
        end
        chk("drained_stall", {31'b0, fetch_stall}, 32'h0);
        drive(0, 0, 0, 0, 0, 1, 32'h30, 1, 1, 32'h1030);
        chk("empty_pop_update", {31'b0, update}, 32'h0);
        chk("empty_pop_flush",  {31'b0, flush},  32'h0);

        // Head pc 0x504 vs ex_pc 0x500: sticky error; resolution uses ex_pc.
        drive(1, 32'h504, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 32'h500, 0, 0, 0);
        chk("mism_set",      {31'b0, pc_mismatch}, 32'h1);
        chk("mism_flush",    {31'b0, flush},       32'h1);
        chk("mism_redirect", redirect_pc,          32'h504);
        idle();
        idle();
        chk("mism_sticky",   {31'b0, pc_mismatch}, 32'h1);
        chk("mism_flush_off",{31'b0, flush},       32'h0);

        // Async reset between edges with 3 entries queued.
        drive(1, 32'h600, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 32'h604, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 32'h608, 0, 0, 0, 0, 0, 0, 0, 0);
        if_valid = 0;
        #2 rst = 1'b1;
        #1;
        chk("arst_mism",     {31'b0, pc_mismatch}, 32'h0);
        chk("arst_redirect", redirect_pc,          32'h0);
        chk("arst_update_pc",update_pc,            32'h0);
        chk("arst_stall",    {31'b0, fetch_stall}, 32'h0);
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 1, 32'h600, 1, 1, 32'h999);
            chk($sformatf("post_rst%0d_update", i), {31'b0, update}, 32'h0);
            chk($sformatf("post_rst%0d_flush", i),  {31'b0, flush},  32'h0);
        end
        chk("post_rst_stall", {31'b0, fetch_stall}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
